// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out serializer. Words arrive over a valid/ready
// handshake and leave one bit per clock on serial_out. A one-entry holding
// register lets the next word wait behind the one being shifted, so words
// stream back to back with no idle bit between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: shift the MSB out first, 0: shift the LSB out first
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous active-high reset, wins over everything
//   par_in        parallel word from upstream
//   in_valid      par_in holds a word to transfer
//   in_ready      a word can be taken this cycle (= holding register empty)
//   serial_out    current serial bit (0 when idle)
//   serial_valid  serial_out carries a data bit
//   frame_start   high while bit 0 of a word is presented
//   word_done     high while the last bit of a word is presented
//   busy          shifting, or a word is waiting in the holding register
//
// Handshake: a word moves on every rising edge where in_valid && in_ready.
// in_ready depends only on registered state, never on in_valid. While
// in_valid is high and in_ready low, upstream holds par_in stable; such a
// cycle has no effect on this block.
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             word_done,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic serial_out_q, serial_out_d;
    logic serial_valid_q, serial_valid_d;
    logic frame_start_q, frame_start_d;
    logic word_done_q, word_done_d;
    logic busy_q, busy_d;

    logic xfer;
    logic shifting_next;

    assign in_ready = !hold_full_q;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        count_d     = count_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shreg_d = par_in;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q == LAST) begin
                    // Word boundary: a held word beats a fresh transfer. Both
                    // cannot happen together because in_ready is low while
                    // the holding register is full.
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        count_d     = '0;
                    end else if (xfer) begin
                        shreg_d = par_in;
                        count_d = '0;
                    end else begin
                        shreg_d = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                    count_d = count_q + CW'(1);
                    if (xfer) begin
                        hold_d      = par_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so that the first
    // bit of an accepted word appears right after the accepting edge.
    always_comb begin
        shifting_next  = (state_d == SHIFT);
        serial_valid_d = shifting_next;
        serial_out_d   = shifting_next &&
                         (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
        frame_start_d  = shifting_next && (count_d == '0);
        word_done_d    = shifting_next && (count_d == LAST);
        busy_d         = shifting_next || hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            count_q        <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            word_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            count_q        <= count_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_start_q  <= frame_start_d;
            word_done_q    <= word_done_d;
            busy_q         <= busy_d;
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_start  = frame_start_q;
    assign word_done    = word_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Drives an MSB-first and an LSB-first piso_serializer from the same inputs.
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// so each check sees the result of the edge just taken. A small 8-bit
// MSB-first shift register stands in for the downstream sipo.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    // ---------------- clock / reset / signals ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] par_in;

    logic in_ready, serial_out, serial_valid, frame_start, word_done, busy;
    logic in_ready_l, serial_out_l, serial_valid_l, frame_start_l, word_done_l, busy_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .par_in       (par_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .word_done    (word_done),
        .busy         (busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk          (clk),
        .rst          (rst),
        .par_in       (par_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready_l),
        .serial_out   (serial_out_l),
        .serial_valid (serial_valid_l),
        .frame_start  (frame_start_l),
        .word_done    (word_done_l),
        .busy         (busy_l)
    );

    // Downstream sipo stand-in: shifts in MSB first on every valid bit.
    logic [7:0] sipo_q = 8'h00;
    always @(posedge clk) begin
        if (serial_valid) sipo_q <= {sipo_q[6:0], serial_out};
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial monitor for the streaming sequence.
    logic exp_q[$];
    logic obs_q[$];
    int   fs_pos[$];
    int   wd_pos[$];
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   first_v = -1;
    int   last_v = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (serial_valid) begin
                if (first_v < 0) first_v = cyc;
                obs_q.push_back(serial_out);
                if (frame_start) fs_pos.push_back(cyc - first_v);
                if (word_done)   wd_pos.push_back(cyc - first_v);
                last_v = cyc;
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    logic acc;  // did the edge just taken transfer a word

    task automatic tick();
        acc = in_valid && in_ready && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        par_in   = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       so;
        logic       sv;
        logic       fs;
        logic       wd;
        logic       bz;
        logic       rdy;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int   lowcnt;
        int   waited;
        logic got;
        int   hi_cnt;
        logic [7:0] words [3];
        logic [7:0] wl;

        // rst, vld, data, | so, sv, fs, wd, busy, rdy
        vecs[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b1;
        par_in   = 8'hFF;

        // ---- reset with in_valid held, then a single word 8'hA5 ----
        for (int i = 0; i < 13; i++) begin
            rst      = vecs[i].rst;
            in_valid = vecs[i].vld;
            par_in   = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_serial_out", i),   32'(serial_out),   32'(vecs[i].so));
            chk($sformatf("vec%0d_serial_valid", i), 32'(serial_valid), 32'(vecs[i].sv));
            chk($sformatf("vec%0d_frame_start", i),  32'(frame_start),  32'(vecs[i].fs));
            chk($sformatf("vec%0d_word_done", i),    32'(word_done),    32'(vecs[i].wd));
            chk($sformatf("vec%0d_busy", i),         32'(busy),         32'(vecs[i].bz));
            chk($sformatf("vec%0d_in_ready", i),     32'(in_ready),     32'(vecs[i].rdy));
        end
        chk("sipo_loopback_a5", 32'(sipo_q), 32'h0000_00A5);

        // ---- back-to-back A5, 3C, then FF under backpressure ----
        do_reset();
        obs_q.delete();
        fs_pos.delete();
        wd_pos.delete();
        cyc     = 0;
        first_v = -1;
        last_v  = -1;
        mon_en  = 1'b1;

        in_valid = 1'b1;
        par_in   = 8'hA5;
        tick();
        chk("b2b_accept_a5", 32'(acc), 32'd1);
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        par_in   = 8'h3C;
        tick();
        chk("b2b_accept_3c", 32'(acc), 32'd1);
        chk("b2b_ready_low_after_hold", 32'(in_ready), 32'd0);
        chk("b2b_busy_with_hold", 32'(busy), 32'd1);

        par_in = 8'hFF;
        lowcnt = 0;
        waited = 0;
        got    = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            waited++;
            if (acc) got = 1'b1;
            else if (!in_ready) lowcnt++;
        end
        chk("ff_accepted", 32'(got), 32'd1);
        chk("ff_wait_edges", 32'(waited), 32'd7);
        chk("ready_low_cycles", 32'(lowcnt), 32'd5);
        in_valid = 1'b0;
        par_in   = 8'h00;
        repeat (30) tick();
        mon_en = 1'b0;

        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hFF;
        exp_q.delete();
        for (int w = 0; w < 3; w++) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back(words[w][b]);
        end
        chk("stream_bit_count", 32'(obs_q.size()), 32'd24);
        for (int i = 0; i < 24; i++) begin
            if (i < obs_q.size()) begin
                chk($sformatf("stream_bit%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
            end else begin
                chk($sformatf("stream_bit%0d_missing", i), 32'd0, 32'd1);
            end
        end
        chk("stream_contiguous_span", 32'(last_v - first_v + 1), 32'd24);
        chk("frame_start_count", 32'(fs_pos.size()), 32'd3);
        chk("word_done_count", 32'(wd_pos.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < fs_pos.size()) chk($sformatf("frame_start_pos%0d", i), 32'(fs_pos[i]), 32'(i * 8));
            if (i < wd_pos.size()) chk($sformatf("word_done_pos%0d", i), 32'(wd_pos[i]), 32'(i * 8 + 7));
        end
        chk("stream_end_busy", 32'(busy), 32'd0);
        chk("stream_end_ready", 32'(in_ready), 32'd1);

        // ---- reset mid-word with a word held ----
        do_reset();
        in_valid = 1'b1;
        par_in   = 8'hA5;
        tick();
        chk("mid_accept_a5", 32'(acc), 32'd1);
        par_in = 8'h3C;
        tick();
        chk("mid_accept_3c", 32'(acc), 32'd1);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_serial_valid", 32'(serial_valid), 32'd0);
        chk("mid_rst_serial_out", 32'(serial_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_frame_start", 32'(frame_start), 32'd0);
        chk("mid_rst_word_done", 32'(word_done), 32'd0);
        hi_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (serial_valid || busy || serial_out) hi_cnt++;
        end
        chk("mid_rst_no_leftover_bits", 32'(hi_cnt), 32'd0);

        // ---- LSB-first instance with 8'h01 ----
        do_reset();
        wl       = 8'h01;
        in_valid = 1'b1;
        par_in   = wl;
        tick();
        chk("lsb_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        par_in   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_bit%0d", i), 32'(serial_out_l), 32'(wl[i]));
            chk($sformatf("lsb_valid%0d", i), 32'(serial_valid_l), 32'd1);
            chk($sformatf("lsb_frame_start%0d", i), 32'(frame_start_l), 32'(i == 0));
            chk($sformatf("lsb_word_done%0d", i), 32'(word_done_l), 32'(i == 7));
            tick();
        end
        chk("lsb_idle_valid", 32'(serial_valid_l), 32'd0);
        chk("lsb_idle_busy", 32'(busy_l), 32'd0);
        chk("lsb_idle_ready", 32'(in_ready_l), 32'd1);

        // ---- report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
